// File: rtl/upc_sequencer_if.sv
// Sequencing bus between the control-store micro-word/IR decode and the micro-address sequencer.
// The sequencer takes the slave modport; whoever drives the micro-word takes master.
interface upc_sequencer_if #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 8
);
    localparam int unsigned SpW = $clog2(DEPTH + 1);

    logic           run;
    logic [2:0]     op;
    logic [AW-1:0]  br_addr;
    logic [AW-1:0]  map_addr;
    logic [3:0]     cond;
    logic [1:0]     cond_sel;
    logic           cond_inv;
    logic [AW-1:0]  upc;
    logic [SpW-1:0] sp;
    logic [CW-1:0]  cnt;
    logic           err;

    modport master (
        output run, op, br_addr, map_addr, cond, cond_sel, cond_inv,
        input  upc, sp, cnt, err
    );

    modport slave (
        input  run, op, br_addr, map_addr, cond, cond_sel, cond_inv,
        output upc, sp, cnt, err
    );
endinterface

// File: rtl/upc_sequencer.sv
// Microprogram address sequencer: next/jump/conditional/map/call/return/load-count/loop.
// Return stack and stack-fault halt exist only when UPC_STACK_EN is defined.
module upc_sequencer #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 8
) (
    input  logic           clk,
    input  logic           rst,
    upc_sequencer_if.slave bus
);
    localparam int unsigned SpW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OpNext = 3'b000,
        OpJmp  = 3'b001,
        OpJcc  = 3'b010,
        OpMap  = 3'b011,
        OpCall = 3'b100,
        OpRet  = 3'b101,
        OpLdc  = 3'b110,
        OpLoop = 3'b111
    } op_e;

    op_e           op;
    logic [AW-1:0] upc_q, upc_d, upc_inc;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          take;
    logic          adv;

    assign op = op_e'(bus.op);

`ifdef UPC_STACK_EN
    localparam int unsigned    IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SpW-1:0] SpFull = SpW'(DEPTH);

    logic [SpW-1:0]  sp_q, sp_d;
    logic            err_q, err_d;
    logic            push;
    logic [AW-1:0]   stack_q [DEPTH];
    logic [IdxW-1:0] push_idx, top_idx;

    assign push_idx = IdxW'(sp_q);
    assign top_idx  = IdxW'(sp_q - 1'b1);
    // A stack fault halts the sequencer until reset.
    assign adv      = bus.run & ~err_q;
`else
    assign adv      = bus.run;
`endif

    always_comb begin
        upc_inc = upc_q + 1'b1;
        take    = bus.cond[bus.cond_sel] ^ bus.cond_inv;
        upc_d   = upc_q;
        cnt_d   = cnt_q;
`ifdef UPC_STACK_EN
        sp_d    = sp_q;
        err_d   = err_q;
        push    = 1'b0;
`endif
        if (adv) begin
            unique case (op)
                OpNext: upc_d = upc_inc;
                OpJmp:  upc_d = bus.br_addr;
                OpJcc:  upc_d = take ? bus.br_addr : upc_inc;
                OpMap:  upc_d = bus.map_addr;
`ifdef UPC_STACK_EN
                OpCall: begin
                    if (sp_q == SpFull) begin
                        err_d = 1'b1;
                    end else begin
                        push  = 1'b1;
                        sp_d  = sp_q + 1'b1;
                        upc_d = bus.br_addr;
                    end
                end
                OpRet: begin
                    if (sp_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        sp_d  = sp_q - 1'b1;
                        upc_d = stack_q[top_idx];
                    end
                end
`else
                OpCall: upc_d = bus.br_addr;
                OpRet:  upc_d = upc_inc;
`endif
                OpLdc: begin
                    cnt_d = bus.br_addr[CW-1:0];
                    upc_d = upc_inc;
                end
                OpLoop: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        upc_d = bus.br_addr;
                    end else begin
                        upc_d = upc_inc;
                    end
                end
                default: upc_d = upc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc_q <= '0;
            cnt_q <= '0;
        end else begin
            upc_q <= upc_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef UPC_STACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Entries above sp are don't-care, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[push_idx] <= upc_inc;
        end
    end

    assign bus.sp  = sp_q;
    assign bus.err = err_q;
`else
    assign bus.sp  = SpW'(0);
    assign bus.err = 1'b0;
`endif

    assign bus.upc = upc_q;
    assign bus.cnt = cnt_q;
endmodule

// File: tb/tb_upc_sequencer.sv
// Directed bench for upc_sequencer; expectations adapt to whether UPC_STACK_EN is defined.
module tb_upc_sequencer;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 8;

`ifdef UPC_STACK_EN
    localparam bit HasStack = 1'b1;
`else
    localparam bit HasStack = 1'b0;
`endif

    localparam logic [2:0] NEXT = 3'd0, JMP = 3'd1, JCC = 3'd2, MAP = 3'd3;
    localparam logic [2:0] CALL = 3'd4, RET = 3'd5, LDC = 3'd6, LOOP = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    upc_sequencer_if #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) bus ();

    upc_sequencer #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply one micro-word, clock it in, sample 1 ns after the edge.
    task automatic step(input logic [2:0] op, input logic [7:0] br, input logic [7:0] map,
                        input logic [3:0] cond, input logic [1:0] sel, input logic inv,
                        input logic run);
        bus.op       = op;
        bus.br_addr  = br;
        bus.map_addr = map;
        bus.cond     = cond;
        bus.cond_sel = sel;
        bus.cond_inv = inv;
        bus.run      = run;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [2:0] op, input logic [7:0] br);
        step(op, br, 8'h00, 4'h0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic check_state(input string tag, input logic [7:0] upc, input logic [2:0] sp,
                               input logic [7:0] cnt, input logic err);
        check({tag, ".upc"}, 32'(bus.upc), 32'(upc));
        check({tag, ".sp"},  32'(bus.sp),  32'(sp));
        check({tag, ".cnt"}, 32'(bus.cnt), 32'(cnt));
        check({tag, ".err"}, 32'(bus.err), 32'(err));
    endtask

    // Reset asserted mid-cycle; state must clear before the next clock edge.
    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_state("async_rst", 8'h00, 3'd0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.run = 1'b0; bus.op = NEXT; bus.br_addr = '0; bus.map_addr = '0;
        bus.cond = '0; bus.cond_sel = '0; bus.cond_inv = 1'b0;
        reset_pulse();

        // Free-running count with wrap.
        for (int i = 1; i <= 300; i++) begin
            go(NEXT, 8'h00);
            check("count", 32'(bus.upc), 32'(i % 256));
        end
        reset_pulse();

        // Conditional branch on Z, then inverted, then false on N; map dispatch.
        go(JMP, 8'h05);
        check("jmp", 32'(bus.upc), 32'h05);
        step(JCC, 8'h40, 8'h00, 4'b0010, 2'd1, 1'b0, 1'b1);
        check("jcc_taken", 32'(bus.upc), 32'h40);
        go(JMP, 8'h05);
        step(JCC, 8'h40, 8'h00, 4'b0010, 2'd1, 1'b1, 1'b1);
        check("jcc_inv", 32'(bus.upc), 32'h06);
        step(JCC, 8'h40, 8'h00, 4'b0010, 2'd2, 1'b0, 1'b1);
        check("jcc_n_false", 32'(bus.upc), 32'h07);
        step(JCC, 8'h40, 8'h00, 4'b1000, 2'd3, 1'b0, 1'b1);
        check("jcc_v_true", 32'(bus.upc), 32'h40);
        step(MAP, 8'h00, 8'h9a, 4'h0, 2'd0, 1'b0, 1'b1);
        check("map", 32'(bus.upc), 32'h9a);

        // Nested call/return.
        go(JMP, 8'h03);
        go(CALL, 8'h10);
        check_state("call1", 8'h10, HasStack ? 3'd1 : 3'd0, 8'h00, 1'b0);
        go(NEXT, 8'h00);
        go(CALL, 8'h20);
        check_state("call2", 8'h20, HasStack ? 3'd2 : 3'd0, 8'h00, 1'b0);
        go(RET, 8'h00);
        check_state("ret1", HasStack ? 8'h12 : 8'h21, HasStack ? 3'd1 : 3'd0, 8'h00, 1'b0);
        go(RET, 8'h00);
        check_state("ret2", HasStack ? 8'h04 : 8'h22, 3'd0, 8'h00, 1'b0);

        // Hardware loop: 3 branches then fall through.
        go(JMP, 8'h30);
        go(LDC, 8'h03);
        check_state("ldc", 8'h31, 3'd0, 8'h03, 1'b0);
        for (int k = 2; k >= 0; k--) begin
            go(LOOP, 8'h30);
            check("loop_upc", 32'(bus.upc), 32'h30);
            check("loop_cnt", 32'(bus.cnt), 32'(k));
            go(NEXT, 8'h00);
        end
        go(LOOP, 8'h30);
        check_state("loop_exit", 8'h32, 3'd0, 8'h00, 1'b0);

        // Hold: run=0 must freeze everything.
        go(LDC, 8'h55);
        step(CALL, 8'h77, 8'h00, 4'h0, 2'd0, 1'b0, 1'b0);
        check_state("hold_call", 8'h33, 3'd0, 8'h55, 1'b0);
        step(LOOP, 8'h10, 8'h00, 4'h0, 2'd0, 1'b0, 1'b0);
        check_state("hold_loop", 8'h33, 3'd0, 8'h55, 1'b0);

        // Stack overflow: 4 calls fill, 5th faults and halts.
        reset_pulse();
        go(CALL, 8'h10);
        go(CALL, 8'h20);
        go(CALL, 8'h30);
        go(CALL, 8'h40);
        check_state("fill", 8'h40, HasStack ? 3'd4 : 3'd0, 8'h00, 1'b0);
        go(CALL, 8'h50);
        check_state("overflow", HasStack ? 8'h40 : 8'h50, HasStack ? 3'd4 : 3'd0, 8'h00,
                    HasStack);
        go(NEXT, 8'h00);
        check_state("halted", HasStack ? 8'h40 : 8'h51, HasStack ? 3'd4 : 3'd0, 8'h00,
                    HasStack);
        go(LDC, 8'h09);
        check_state("halted_ldc", HasStack ? 8'h40 : 8'h52, HasStack ? 3'd4 : 3'd0,
                    HasStack ? 8'h00 : 8'h09, HasStack);

        // Stack underflow right after reset.
        reset_pulse();
        go(RET, 8'h00);
        check_state("underflow", HasStack ? 8'h00 : 8'h01, 3'd0, 8'h00, HasStack);
        step(NEXT, 8'h00, 8'h00, 4'h0, 2'd0, 1'b0, 1'b0);
        check_state("underflow_hold", HasStack ? 8'h00 : 8'h01, 3'd0, 8'h00, HasStack);
        reset_pulse();
        go(NEXT, 8'h00);
        check_state("after_clear", 8'h01, 3'd0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
